// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, error causes
// and default geometry/latency.
package data_mem_responder_pkg;

  localparam int DMEM_DEPTH_DEFAULT   = 256;
  localparam int DMEM_LATENCY_DEFAULT = 2;
  localparam int CNT_W                = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } dmem_state_t;

  typedef enum logic [2:0] {
    ERR_NONE       = 3'd0,
    ERR_NEGATIVE   = 3'd1,
    ERR_MISALIGNED = 3'd2,
    ERR_RANGE      = 3'd3,
    ERR_CONFLICT   = 3'd4
  } dmem_err_t;

  // First matching cause wins; span is the byte size of the memory.
  function automatic dmem_err_t dmem_classify(
    input logic signed [63:0] addr,
    input logic               rd,
    input logic               wr,
    input logic        [63:0] span
  );
    dmem_err_t cause;
    cause = ERR_NONE;
    if (rd && wr) begin
      cause = ERR_CONFLICT;
    end else if (addr < 0) begin
      cause = ERR_NEGATIVE;
    end else if (addr[2:0] != 3'b000) begin
      cause = ERR_MISALIGNED;
    end else if ($unsigned(addr) >= span) begin
      cause = ERR_RANGE;
    end
    return cause;
  endfunction

endpackage

// File: rtl/data_mem_responder_dmem_array.sv
// Single-port DEPTH x 64 RAM: synchronous write, registered read.
// Contents are deliberately not reset.
module dmem_array #(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [63:0]              wdata,
  output logic [63:0]              rdata
);

  logic [63:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Latency-programmable data-memory responder: accepts one read or write in IDLE,
// completes it LATENCY edges later and pulses mem_done for one cycle.
//
// state | meaning
// IDLE  | mem_ready high, waiting for read_enable/write_enable
// BUSY  | request captured, counting down to the access edge
// DONE  | access finished, mem_done high for this cycle
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH   = DMEM_DEPTH_DEFAULT,
  parameter int LATENCY = DMEM_LATENCY_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               read_enable,
  input  logic               write_enable,
  input  logic signed [63:0] mem_address,
  input  logic signed [63:0] mem_data,
  output logic               mem_ready,
  output logic               mem_done,
  output logic signed [63:0] valM,
  output logic               dmem_error
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [63:0]     SPAN     = 64'(DEPTH) * 64'd8;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  dmem_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             is_rd_q, is_wr_q;
  dmem_err_t        cause_q;
  logic [AW-1:0]    idx_q;
  logic [63:0]      wdata_q;

  logic             accept, complete;
  logic             ram_we;
  logic [AW-1:0]    ram_addr;
  logic [63:0]      ram_rdata;

  assign mem_ready = (state_q == ST_IDLE);
  assign mem_done  = (state_q == ST_DONE);
  assign accept    = (state_q == ST_IDLE) && (read_enable || write_enable);
  assign complete  = (state_q == ST_BUSY) && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (read_enable || write_enable) state_d = ST_BUSY;
      ST_BUSY: if (cnt_q == '0) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      is_rd_q    <= 1'b0;
      is_wr_q    <= 1'b0;
      cause_q    <= ERR_NONE;
      idx_q      <= '0;
      wdata_q    <= '0;
      valM       <= '0;
      dmem_error <= 1'b0;
    end else begin
      if (accept) begin
        cnt_q   <= CNT_INIT;
        is_rd_q <= read_enable;
        is_wr_q <= write_enable;
        cause_q <= dmem_classify(mem_address, read_enable, write_enable, SPAN);
        idx_q   <= mem_address[AW+2:3];
        wdata_q <= mem_data;
      end else if ((state_q == ST_BUSY) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end

      if (complete) begin
        if (cause_q != ERR_NONE) begin
          dmem_error <= 1'b1;
          if (is_rd_q) valM <= '0;
        end else begin
          dmem_error <= 1'b0;
          if (is_rd_q) valM <= ram_rdata;
        end
      end
    end
  end

  // The RAM reads the live address in IDLE so its registered output is
  // already valid at the access edge, even when LATENCY is 1.
  assign ram_addr = (state_q == ST_IDLE) ? mem_address[AW+2:3] : idx_q;
  assign ram_we   = complete && is_wr_q && (cause_q == ERR_NONE) && !reset;

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_dmem_array (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder: two instances (LATENCY 2 and 1)
// checked against a transaction-level memory model.
module tb_data_mem_responder;

  localparam int DEPTH = 256;
  localparam int LAT0  = 2;
  localparam int LAT1  = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst [2];
  logic               re  [2];
  logic               we  [2];
  logic signed [63:0] ad  [2];
  logic signed [63:0] dt  [2];
  logic               rdy [2];
  logic               dn  [2];
  logic signed [63:0] vm  [2];
  logic               er  [2];

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT0)) u0 (
    .clk(clk), .reset(rst[0]), .read_enable(re[0]), .write_enable(we[0]),
    .mem_address(ad[0]), .mem_data(dt[0]), .mem_ready(rdy[0]),
    .mem_done(dn[0]), .valM(vm[0]), .dmem_error(er[0])
  );

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT1)) u1 (
    .clk(clk), .reset(rst[1]), .read_enable(re[1]), .write_enable(we[1]),
    .mem_address(ad[1]), .mem_data(dt[1]), .mem_ready(rdy[1]),
    .mem_done(dn[1]), .valM(vm[1]), .dmem_error(er[1])
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] mdl [2][DEPTH];
  logic [63:0] exp_val [2];
  logic        exp_err [2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the instance idle; returns at the negedge after DONE.
  task automatic txn(input int s, input bit rd, input bit wr, input logic [63:0] addr,
                     input logic [63:0] data, input string tag);
    int  lat;
    int  seen;
    bit  busy_ready;
    bit  bad;
    longint sa;
    lat = (s == 0) ? LAT0 : LAT1;
    chk({tag, "_ready"}, 64'(rdy[s]), 64'd1);
    re[s] = rd; we[s] = wr; ad[s] = addr; dt[s] = data;
    @(negedge clk);
    re[s] = 1'b0; we[s] = 1'b0;
    seen = 0;
    busy_ready = 1'b0;
    for (int i = 1; i <= 20 && seen == 0; i++) begin
      if (rdy[s]) busy_ready = 1'b1;
      if (dn[s]) seen = i;
      else @(negedge clk);
    end
    chk({tag, "_latency"}, 64'(seen), 64'(lat + 1));
    chk({tag, "_ready_low"}, 64'(busy_ready), 64'd0);

    sa  = longint'(addr);
    bad = (rd && wr) || (sa < 0) || (sa % 8 != 0) || (sa >= longint'(DEPTH) * 8);
    if (bad) begin
      exp_err[s] = 1'b1;
      if (rd) exp_val[s] = '0;
    end else begin
      exp_err[s] = 1'b0;
      if (rd) exp_val[s] = mdl[s][sa / 8];
      else    mdl[s][sa / 8] = data;
    end
    chk({tag, "_valM"}, vm[s], exp_val[s]);
    chk({tag, "_err"}, 64'(er[s]), 64'(exp_err[s]));

    @(negedge clk);
    chk({tag, "_done_drop"}, 64'(dn[s]), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, dcnt, seen_done, r, idx;
    longint a;
    logic [63:0] d;
    bit rd, wr;

    for (int s = 0; s < 2; s++) begin
      rst[s] = 1'b1; re[s] = 1'b0; we[s] = 1'b0; ad[s] = '0; dt[s] = '0;
      exp_val[s] = '0; exp_err[s] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    for (int s = 0; s < 2; s++) begin
      chk("reset_ready", 64'(rdy[s]), 64'd1);
      chk("reset_done", 64'(dn[s]), 64'd0);
      chk("reset_valM", vm[s], 64'd0);
      chk("reset_err", 64'(er[s]), 64'd0);
    end

    // Give every location a known value so random reads are fully predictable.
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < DEPTH; i++)
        txn(s, 1'b0, 1'b1, 64'(i * 8), {$urandom, $urandom}, "init_wr");

    txn(0, 1'b0, 1'b1, 64'h40, 64'h1122334455667788, "w40");
    txn(0, 1'b1, 1'b0, 64'h40, 64'h0, "r40");
    chk("r40_const", vm[0], 64'h1122334455667788);

    txn(0, 1'b1, 1'b0, 64'h43, 64'h0, "r43_misaligned");
    chk("r43_const_err", 64'(er[0]), 64'd1);
    txn(0, 1'b1, 1'b0, -64'sd8, 64'h0, "rneg");
    chk("rneg_const_val", vm[0], 64'd0);
    txn(0, 1'b1, 1'b0, 64'h800, 64'h0, "r800_range");
    chk("r800_const_err", 64'(er[0]), 64'd1);
    txn(0, 1'b1, 1'b0, 64'h40, 64'h0, "r40_again");
    chk("r40_again_const", vm[0], 64'h1122334455667788);

    txn(0, 1'b1, 1'b1, 64'h10, 64'hFF, "both_en");
    chk("both_en_const_err", 64'(er[0]), 64'd1);
    txn(0, 1'b1, 1'b0, 64'h10, 64'h0, "r10_after_both");

    // Request held continuously: one acceptance every LAT0+2 cycles.
    ad[0] = 64'h40; re[0] = 1'b1;
    acc = 0; dcnt = 0;
    for (int i = 0; i < 3 * (LAT0 + 2); i++) begin
      if (rdy[0]) acc++;
      if (dn[0]) dcnt++;
      @(negedge clk);
    end
    re[0] = 1'b0;
    chk("hold_accepts", 64'(acc), 64'd3);
    chk("hold_dones", 64'(dcnt), 64'd3);
    exp_val[0] = mdl[0][8]; exp_err[0] = 1'b0;
    chk("hold_valM", vm[0], exp_val[0]);

    // Reset one cycle after a write is accepted.
    d = mdl[0][1];
    chk("rstmid_ready", 64'(rdy[0]), 64'd1);
    we[0] = 1'b1; ad[0] = 64'h08; dt[0] = 64'hAA;
    @(negedge clk);
    we[0] = 1'b0; rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 6; i++) begin
      if (dn[0]) seen_done = 1;
      @(negedge clk);
    end
    chk("rstmid_no_done", 64'(seen_done), 64'd0);
    chk("rstmid_valM", vm[0], 64'd0);
    chk("rstmid_err", 64'(er[0]), 64'd0);
    chk("rstmid_ready_after", 64'(rdy[0]), 64'd1);
    exp_val[0] = '0; exp_err[0] = 1'b0;
    txn(0, 1'b1, 1'b0, 64'h08, 64'h0, "r08_after_rst");
    chk("r08_old_value", vm[0], d);

    txn(1, 1'b0, 1'b1, 64'h18, 64'h5, "lat1_w18");
    txn(1, 1'b1, 1'b0, 64'h18, 64'h0, "lat1_r18");
    chk("lat1_r18_const", vm[1], 64'h5);

    for (int n = 0; n < 150; n++) begin
      for (int s = 0; s < 2; s++) begin
        idx = $urandom_range(0, DEPTH - 1);
        case ($urandom_range(0, 9))
          0:       a = longint'(idx) * 8 + longint'($urandom_range(1, 7));
          1:       a = -8 * longint'($urandom_range(1, 100));
          2:       a = longint'(DEPTH) * 8 + 8 * longint'($urandom_range(0, 50));
          default: a = longint'(idx) * 8;
        endcase
        r = $urandom_range(0, 9);
        rd = (r == 0) || (r >= 5);
        wr = (r <= 4);
        txn(s, rd, wr, 64'(a), {$urandom, $urandom}, "rand");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning the number of 64-bit quadwords in data memory (byte span DEPTH*8).
REQ-002 SHALL have parameter LATENCY, default 2, meaning the number of clock edges from request acceptance to completion; the legal range is 1 to 15.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port read_enable, input, 1 bit: read request from the memory-stage initiator.
REQ-006 SHALL have port write_enable, input, 1 bit: write request from the memory-stage initiator.
REQ-007 SHALL have port mem_address, input, 64 bits, signed: the byte address.
REQ-008 SHALL have port mem_data, input, 64 bits, signed: the write data.
REQ-009 SHALL have port mem_ready, output, 1 bit: high only in IDLE, meaning a request is accepted this cycle.
REQ-010 SHALL have port mem_done, output, 1 bit: a one-cycle completion pulse.
REQ-011 SHALL have port valM, output, 64 bits, signed: the read data.
REQ-012 SHALL have port dmem_error, output, 1 bit: error status of the last completed transaction.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-014 In IDLE with (read_enable|write_enable)=1 at posedge, SHALL capture type, mem_address and mem_data, load cnt=LATENCY-1, and go to BUSY.
REQ-015 SHALL ignore the enables whenever mem_ready=0; the initiator holds the request until accepted.
REQ-016 In BUSY with cnt!=0, SHALL decrement cnt each edge.
REQ-017 In BUSY with cnt==0, SHALL perform the access at that edge, update valM and dmem_error, and go to DONE.
REQ-018 mem_done SHALL be high exactly during DONE, i.e. the cycle after edge t0+LATENCY, where t0 is the acceptance edge.
REQ-019 DONE SHALL go to IDLE unconditionally on the next edge, giving a throughput of one transaction per LATENCY+2 cycles.
REQ-020 SHALL flag a request as erroneous if mem_address<0, mem_address[2:0]!=0, mem_address>=DEPTH*8, or both enables are high at acceptance.
REQ-021 A valid read SHALL set valM=mem[mem_address>>3] and dmem_error=0.
REQ-022 A valid write SHALL store mem_data at mem[mem_address>>3], leave valM unchanged, and set dmem_error=0.
REQ-023 An erroneous request SHALL not modify memory, SHALL set dmem_error=1, and SHALL set valM=0 if the request was a read.
REQ-024 valM and dmem_error SHALL hold their values until the next completion.
REQ-025 A read issued after a completed write to the same address SHALL return the written data.

Reset
REQ-026 Reset SHALL set state=IDLE, cnt=0, valM=0, mem_done=0 and dmem_error=0; mem_ready is 1 in the cycle after reset.
REQ-027 Reset asserted in BUSY or DONE SHALL abort the transaction, drop any pending write, and suppress mem_done.
REQ-028 Memory contents SHALL not be cleared by reset.
REQ-029 Reset SHALL take priority over a request arriving in the same cycle.

Structure
REQ-030 SHALL place the FSM state encoding, icode-independent error-cause constants and the default DEPTH/LATENCY values in the shared pipeline package.
REQ-031 SHALL instantiate one sub-module, dmem_array: a synchronous-write, registered-read DEPTH x 64 RAM with a single port.
REQ-032 SHALL keep the FSM, counter and error check in data_mem_responder itself.

Verification
REQ-033 With LATENCY=2: write 0x1122334455667788 to address 0x40, then read 0x40 -> read mem_done exactly 2 cycles after acceptance, valM=0x1122334455667788, dmem_error=0.
REQ-034 A read of address 0x43 (misaligned), of -8, or of 0x800 with DEPTH=256 -> dmem_error=1 and valM=0; a following read of 0x40 still returns the prior data.
REQ-035 read_enable=write_enable=1 with address 0x10 and data 0xFF -> dmem_error=1, and a later read of 0x10 shows unchanged contents.
REQ-036 Holding read_enable high continuously -> exactly one acceptance per LATENCY+2 cycles, mem_ready low throughout BUSY and DONE.
REQ-037 Write 0xAA to 0x08, with reset asserted one cycle after acceptance -> no mem_done, a later read of 0x08 returns the old value, and valM=0 after reset.
REQ-038 With LATENCY=1: back-to-back write and read of 0x18 with 0x5 -> mem_done 1 cycle after each acceptance, and the read returns 0x5.
